// File: rtl/alu_arbiter.sv
// Two-requester arbiter for a shared single-cycle ALU with a registered result slot.
// Define ALU_ARB_RR_EN for round-robin priority; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [1:0]           i_req_valid,
    output logic [1:0]           o_req_ready,
    input  logic [2*WIDTH-1:0]   i_req_a,
    input  logic [2*WIDTH-1:0]   i_req_b,
    input  logic [7:0]           i_req_op,
    output logic [1:0]           o_rsp_valid,
    input  logic [1:0]           i_rsp_ready,
    output logic [WIDTH-1:0]     o_rsp_result,
    output logic                 o_rsp_zero,
    output logic [WIDTH-1:0]     o_alu_operand_a,
    output logic [WIDTH-1:0]     o_alu_operand_b,
    output logic [3:0]           o_alu_op,
    input  logic [WIDTH-1:0]     i_alu_result,
    input  logic                 i_alu_zero
);

    // state  | meaning
    // S_IDLE | no result held
    // S_RESP | result held for r_owner, waiting for its rsp_ready
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_owner;
    logic               w_owner_nxt;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   w_result_nxt;
    logic               r_zero;
    logic               w_zero_nxt;

    logic               w_owner_ready;
    logic               w_slot_free;
    logic               w_any_valid;
    logic               w_winner;
    logic               w_grant;

    assign w_owner_ready = r_owner ? i_rsp_ready[1] : i_rsp_ready[0];
    assign w_slot_free   = (r_state == S_IDLE) || w_owner_ready;
    assign w_any_valid   = |i_req_valid;
    // Gated by reset so no handshake or ALU drive is visible while reset is held.
    assign w_grant       = w_slot_free & w_any_valid & ~i_rst;

`ifdef ALU_ARB_RR_EN
    logic r_last_grant;

    assign w_winner = (&i_req_valid) ? ~r_last_grant : i_req_valid[1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
        end else if (w_grant) begin
            r_last_grant <= w_winner;
        end
    end
`else
    assign w_winner = ~i_req_valid[0];
`endif

    always_comb begin
        o_req_ready     = 2'b00;
        o_alu_operand_a = '0;
        o_alu_operand_b = '0;
        o_alu_op        = 4'd0;
        if (w_grant) begin
            o_req_ready     = w_winner ? 2'b10 : 2'b01;
            o_alu_operand_a = w_winner ? i_req_a[2*WIDTH-1:WIDTH] : i_req_a[WIDTH-1:0];
            o_alu_operand_b = w_winner ? i_req_b[2*WIDTH-1:WIDTH] : i_req_b[WIDTH-1:0];
            o_alu_op        = w_winner ? i_req_op[7:4] : i_req_op[3:0];
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_result_nxt = r_result;
        w_zero_nxt   = r_zero;
        if (w_grant) begin
            w_state_nxt  = S_RESP;
            w_owner_nxt  = w_winner;
            w_result_nxt = i_alu_result;
            w_zero_nxt   = i_alu_zero;
        end else if ((r_state == S_RESP) && w_owner_ready) begin
            w_state_nxt  = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_owner  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_result <= w_result_nxt;
            r_zero   <= w_zero_nxt;
        end
    end

    always_comb begin
        o_rsp_valid = 2'b00;
        if (r_state == S_RESP) begin
            o_rsp_valid = r_owner ? 2'b10 : 2'b01;
        end
    end

    assign o_rsp_result = r_result;
    assign o_rsp_zero   = r_zero;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle ALU between two requesters, typically the integer execute stage (port 0) and the address/branch helper (port 1). Each requester issues operations over a valid/ready request channel and receives results over a valid/ready response channel. The block arbitrates between requesters, drives the ALU's operand and opcode inputs, and registers the ALU result and zero flag. It routes the registered result back to the winning requester. Sustained throughput is one operation per cycle.

## Interface
- WIDTH, 32, operand/result width; must match the ALU's WIDTH
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  2  per-requester request valid, bit i = requester i
- req_ready  out  2  per-requester request accept
- req_a  in  2×WIDTH  operand A per requester
- req_b  in  2×WIDTH  operand B per requester
- req_op  in  2×4  ALU opcode per requester, ALU encoding unchanged
- rsp_valid  out  2  per-requester response valid
- rsp_ready  in  2  per-requester response accept
- rsp_result  out  WIDTH  registered result, shared, qualified by rsp_valid
- rsp_zero  out  1  registered zero flag, shared, qualified by rsp_valid
- alu_operand_a  out  WIDTH  to ALU operand_a
- alu_operand_b  out  WIDTH  to ALU operand_b
- alu_op  out  4  to ALU alu_op
- alu_result  in  WIDTH  from ALU result
- alu_zero  in  1  from ALU zero

## Operation
- States:
  - IDLE: no result held.
  - RESP: a result is held for owner ∈ {0,1}.
- Slot free this cycle = (state==IDLE) OR (state==RESP AND rsp_ready[owner]).
- Arbitration when the slot is free and any req_valid is set:
  - Winner w is chosen from the valid bits (priority rule per Configuration).
  - req_ready[w]=1; the other bit of req_ready is 0.
  - req_ready is 0 for every bit when the slot is not free or no request is valid.
- ALU drive is combinational from the winner's req_a/req_b/req_op. When there is no winner, alu_operand_a, alu_operand_b and alu_op are driven to 0.
- On a request handshake (req_valid[w] & req_ready[w]):
  - alu_result is captured into rsp_result and alu_zero into rsp_zero.
  - owner<=w; state<=RESP.
- In RESP: rsp_valid[owner]=1 and the other bit is 0.
  - Response accepted with no new grant → IDLE; rsp_result and rsp_zero hold their values.
  - Response accepted with a new grant in the same cycle → stay in RESP with the new owner and new data.
- While rsp_ready[owner]=0, the held result and owner stay stable. No further requests are accepted; this is backpressure.
- req_valid without ready: the requester holds its payload stable. A requester that is not granted is not dropped.
- Opcodes 8–15 pass through to the ALU, and the result is 0 by ALU definition. The arbiter does not check them.

## Timing
- Request-to-response latency: 1 cycle. rsp_valid rises on the edge after the request handshake.
- Back-to-back: with rsp_ready held high, one handshake per cycle across both requesters.
- The ALU is combinational, so the path from req_* through the ALU to the capture register lies within one cycle.
- Reset values:
  - state=IDLE, owner=0, last_grant=1 (requester 0 wins first).
  - rsp_valid=0, rsp_result=0, rsp_zero=0.
- Reset asserted mid-operation: a held response is discarded immediately (asynchronously) and the requester never sees it. req_ready, rsp_valid and the ALU drives go to 0 while rst is high.
- Simultaneous response accept and new request from the same requester: both handshakes complete in one cycle, and the new result appears on the next cycle.

## Configuration
- ALU_ARB_RR_EN defined:
  - Round-robin priority: when both requesters are valid, the one not equal to last_grant wins.
  - last_grant updates on every request handshake.
- ALU_ARB_RR_EN undefined:
  - Fixed priority: requester 0 always wins when valid. Requester 1 is granted only when req_valid[0]=0.
  - last_grant is not implemented.

## Test plan
- Single op: requester 0 sends a=5, b=3, op=0001. Required: req_ready[0]=1 in the same cycle; next cycle rsp_valid=01, rsp_result=2, rsp_zero=0.
- Zero flag: requester 1 sends a=7, b=7, op=0001. Required: rsp_valid=10, rsp_result=0, rsp_zero=1.
- Contention, RR build: both requesters valid continuously (op=0000, a=i, b=1), rsp_ready=11. Required: grants alternate 0,1,0,1 and one result per cycle. Fixed-priority build: requester 0 only.
- Backpressure: response pending for requester 0 with rsp_ready=00 for 3 cycles while requester 1 is valid. Required: req_ready=00 and rsp_result stable for all 3 cycles. When rsp_ready[0] rises, requester 1 is granted that same cycle.
- Shift ops: a=0x80000000, b=4 with op 0110 gives 0x08000000; with op 0111 it gives 0xF8000000. b=36 gives the same results as b=4.
- Reset mid-op: assert rst while rsp_valid=01. Required: rsp_valid=00 immediately. After release, simultaneous requests grant requester 0 first.
